// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation controller: hall filter, sector decode, PWM chop, dead time, stall/fault sequencing.
// Optional braking pattern is enabled with `define BLDC_BRAKE_EN (adds the BRAKE input).
module bldc_commutator #(
  parameter int unsigned DEADTIME     = 2,
  parameter int unsigned STALL_CYCLES = 65535
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       DIR,
  input  logic [3:0] DUTY,
  input  logic [2:0] HALL,
  input  logic       FAULT_IN,
  input  logic       CLR_FAULT,
`ifdef BLDC_BRAKE_EN
  input  logic       BRAKE,
`endif
  output logic [2:0] GATE_H,
  output logic [2:0] GATE_L,
  output logic [1:0] STATE,
  output logic       FAULT
);

  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DEAD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         sync0_q, hall_s_q, hist1_q, hist2_q;
  logic [2:0]         hall_acc_q, hall_acc_d;
  logic               hall_loaded_q, hall_loaded_d;
  logic [3:0]         dead_cnt_q, dead_cnt_d;
  logic [2:0]         run_sector_q, run_sector_d;
  logic               run_brake_q, run_brake_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         duty_l_q, duty_l_d;
  logic [2:0]         gate_h_q, gate_h_d, gate_l_q, gate_l_d;

  logic       hall_load, code_ok, hall_bad, stall_hit, pattern_change, pwm_on, brake_req;
  logic [2:0] fwd_sector, sector_d;

`ifdef BLDC_BRAKE_EN
  assign brake_req = BRAKE;
`else
  assign brake_req = 1'b0;
`endif

  function automatic logic [2:0] decode_fwd(input logic [2:0] code);
    case (code)
      3'b001:  return 3'd0;
      3'b011:  return 3'd1;
      3'b010:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b101:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // Sector decisions use the value hall_acc is about to take, so a commutation
  // starts on the same edge the filter accepts a new code.
  always_comb begin
    hall_load     = (hall_s_q == hist1_q) && (hist1_q == hist2_q) && (hall_s_q != hall_acc_q);
    hall_acc_d    = hall_load ? hall_s_q : hall_acc_q;
    hall_loaded_d = hall_loaded_q | hall_load;
    code_ok       = (hall_acc_d != 3'b000) && (hall_acc_d != 3'b111);
    hall_bad      = hall_loaded_d && !code_ok;
    fwd_sector    = decode_fwd(hall_acc_d);
    if (DIR) sector_d = (fwd_sector >= 3'd3) ? fwd_sector - 3'd3 : fwd_sector + 3'd3;
    else     sector_d = fwd_sector;
    pwm_on         = cnt_q < duty_l_q;
    stall_hit      = (state_q == ST_RUN) && (duty_l_q != 4'd0) && !run_brake_q &&
                     (stall_q == STALL_W'(STALL_CYCLES - 1));
    pattern_change = (sector_d != run_sector_q) || (brake_req != run_brake_q);
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_FAULT && (FAULT_IN || hall_bad || stall_hit)) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_FAULT: if (CLR_FAULT && !FAULT_IN) state_d = ST_IDLE;
        ST_IDLE:  if (EN && code_ok) state_d = ST_DEAD;
        ST_DEAD: begin
          if (!EN)                                  state_d = ST_IDLE;
          else if (dead_cnt_q == 4'(DEADTIME - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!EN)                 state_d = ST_IDLE;
          else if (pattern_change) state_d = ST_DEAD;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d        = cnt_q + 4'd1;
    duty_l_d     = duty_l_q;
    if (cnt_q == 4'd15 || (state_q == ST_IDLE && state_d == ST_DEAD)) duty_l_d = DUTY;
    dead_cnt_d   = (state_q == ST_DEAD && state_d == ST_DEAD) ? dead_cnt_q + 4'd1 : 4'd0;
    run_sector_d = run_sector_q;
    run_brake_d  = run_brake_q;
    if (state_q == ST_DEAD && state_d == ST_RUN) begin
      run_sector_d = sector_d;
      run_brake_d  = brake_req;
    end
    stall_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN && !run_brake_q)
      stall_d = (duty_l_q != 4'd0) ? stall_q + 1'b1 : stall_q;
  end

  // Gates follow the registered state one edge later, so every change passes through all-off.
  always_comb begin
    gate_h_d = 3'b000;
    gate_l_d = 3'b000;
    if (state_q == ST_RUN) begin
      if (run_brake_q) begin
        gate_l_d = 3'b111;
      end else begin
        case (run_sector_q)
          3'd0:    begin gate_h_d = 3'b001; gate_l_d = 3'b010; end
          3'd1:    begin gate_h_d = 3'b001; gate_l_d = 3'b100; end
          3'd2:    begin gate_h_d = 3'b010; gate_l_d = 3'b100; end
          3'd3:    begin gate_h_d = 3'b010; gate_l_d = 3'b001; end
          3'd4:    begin gate_h_d = 3'b100; gate_l_d = 3'b001; end
          3'd5:    begin gate_h_d = 3'b100; gate_l_d = 3'b010; end
          default: begin gate_h_d = 3'b000; gate_l_d = 3'b000; end
        endcase
        gate_h_d = gate_h_d & {3{pwm_on}};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      sync0_q       <= '0;
      hall_s_q      <= '0;
      hist1_q       <= '0;
      hist2_q       <= '0;
      hall_acc_q    <= '0;
      hall_loaded_q <= 1'b0;
      dead_cnt_q    <= '0;
      run_sector_q  <= '0;
      run_brake_q   <= 1'b0;
      stall_q       <= '0;
      cnt_q         <= '0;
      duty_l_q      <= '0;
      gate_h_q      <= '0;
      gate_l_q      <= '0;
    end else begin
      state_q       <= state_d;
      sync0_q       <= HALL;
      hall_s_q      <= sync0_q;
      hist1_q       <= hall_s_q;
      hist2_q       <= hist1_q;
      hall_acc_q    <= hall_acc_d;
      hall_loaded_q <= hall_loaded_d;
      dead_cnt_q    <= dead_cnt_d;
      run_sector_q  <= run_sector_d;
      run_brake_q   <= run_brake_d;
      stall_q       <= stall_d;
      cnt_q         <= cnt_d;
      duty_l_q      <= duty_l_d;
      gate_h_q      <= gate_h_d;
      gate_l_q      <= gate_l_d;
    end
  end

  assign GATE_H = gate_h_q;
  assign GATE_L = gate_l_q;
  assign STATE  = state_q;
  assign FAULT  = (state_q == ST_FAULT);

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_bldc_commutator;
  localparam int DT = 2;
  localparam int SC = 100;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, fault_in, clr_fault;
  logic [3:0] duty;
  logic [2:0] hall;
  logic [2:0] gate_h, gate_l;
  logic [1:0] state;
  logic       fault;
`ifdef BLDC_BRAKE_EN
  logic       brake = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  bldc_commutator #(.DEADTIME(DT), .STALL_CYCLES(SC)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIR(dir), .DUTY(duty), .HALL(hall),
    .FAULT_IN(fault_in), .CLR_FAULT(clr_fault),
`ifdef BLDC_BRAKE_EN
    .BRAKE(brake),
`endif
    .GATE_H(gate_h), .GATE_L(gate_l), .STATE(state), .FAULT(fault)
  );

  always #5 clk = ~clk;

  // Behavioural model: sector/pattern tables and hall pin history
  int         fwd_sec[8] = '{-1, 0, 2, 1, 4, 5, 3, -1};
  logic [2:0] hi_tab[6]  = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
  logic [2:0] lo_tab[6]  = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
  logic [2:0] seq[6]     = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  bit         model_on = 0;
  logic [1:0] m_mode;
  logic [2:0] m_gh, m_gl, m_acc;
  logic [2:0] m_p[1:4];
  bit         m_loaded;
  int         m_cnt, m_duty, m_dead_left, m_stall, m_run_sec;

  always @(posedge clk) begin : model
    int s, sec;
    bit ok, bad, expire;
    logic [2:0] nacc;
    bit nloaded;
    logic [1:0] nmode;
    if (!rst_n) begin
      m_mode = 0; m_gh = 0; m_gl = 0; m_acc = 0; m_loaded = 0;
      m_cnt = 0; m_duty = 0; m_dead_left = 0; m_stall = 0; m_run_sec = 0;
      for (int i = 1; i <= 4; i++) m_p[i] = 3'b000;
      model_on = 1;
    end else if (model_on) begin
      if (m_mode == 2) begin
        m_gl = lo_tab[m_run_sec];
        m_gh = (m_cnt < m_duty) ? hi_tab[m_run_sec] : 3'b000;
      end else begin
        m_gl = 3'b000;
        m_gh = 3'b000;
      end
      nacc = m_acc;
      nloaded = m_loaded;
      if (m_p[2] == m_p[3] && m_p[3] == m_p[4] && m_p[2] != m_acc) begin
        nacc = m_p[2];
        nloaded = 1;
      end
      s = fwd_sec[nacc];
      ok = (s >= 0);
      bad = nloaded && !ok;
      sec = ok ? (dir ? (s + 3) % 6 : s) : 0;
      expire = (m_mode == 2) && (m_duty != 0) && (m_stall + 1 >= SC);
      nmode = m_mode;
      if (m_mode != 3 && (fault_in || bad || expire)) nmode = 3;
      else if (m_mode == 3) begin
        if (clr_fault && !fault_in) nmode = 0;
      end else if (m_mode != 0 && !en) nmode = 0;
      else if (m_mode == 0) begin
        if (en && ok) nmode = 1;
      end else if (m_mode == 1) begin
        m_dead_left--;
        if (m_dead_left == 0) begin
          nmode = 2;
          m_run_sec = sec;
        end
      end else if (sec != m_run_sec) nmode = 1;
      if (nmode == 1 && m_mode != 1) m_dead_left = DT;
      if (m_mode == 2 && nmode == 2) begin
        if (m_duty != 0) m_stall++;
      end else m_stall = 0;
      if (m_cnt == 15 || (m_mode == 0 && nmode == 1)) m_duty = duty;
      m_cnt = (m_cnt + 1) % 16;
      m_mode = nmode;
      m_acc = nacc;
      m_loaded = nloaded;
      m_p[4] = m_p[3]; m_p[3] = m_p[2]; m_p[2] = m_p[1]; m_p[1] = hall;
    end
  end

  // Scoreboard compare on the falling edge, away from the sampling edge
  always @(negedge clk) begin
    if (model_on) begin
      checks++;
      if (state !== m_mode || fault !== (m_mode == 2'd3) || gate_h !== m_gh || gate_l !== m_gl) begin
        failures++;
        $display("FAIL model t=%0t state=%b req=%b fault=%b req=%b gate_h=%b req=%b gate_l=%b req=%b",
                 $time, state, m_mode, fault, (m_mode == 2'd3), gate_h, m_gh, gate_l, m_gl);
      end
      checks++;
      if ((gate_h & gate_l) !== 3'b000) begin
        failures++;
        $display("FAIL shoot_through t=%0t gate_h=%b gate_l=%b required_overlap=000", $time, gate_h, gate_l);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [2:0] fwd_codes[4] = '{3'b010, 3'b110, 3'b100, 3'b101};
  logic [2:0] fwd_low[4]   = '{3'b100, 3'b001, 3'b001, 3'b010};

  initial begin
    int n, off, bad, run_c;
    bit seen;
    int hidx, r;
    rst_n = 0; en = 1; dir = 0; duty = 4'd8; hall = 3'b001; fault_in = 0; clr_fault = 0;
    tick(1);
    chk("reset_state", state, 2'b00);
    chk("reset_gates", {gate_h, gate_l}, 6'b0);
    chk("reset_fault", fault, 1'b0);
    tick(2);
    rst_n = 1;
    tick(4); chk("start_idle", state, 2'b00);
    tick(1); chk("start_dead1", state, 2'b01);
    tick(1); chk("start_dead2", state, 2'b01);
    tick(1); chk("start_run", state, 2'b10); chk("start_gates_off", gate_l, 3'b000);
    tick(1); chk("start_gl", gate_l, 3'b010); chk("start_gh_on", gate_h, 3'b001);
    tick(1); chk("start_gh_off", gate_h, 3'b000);
    n = 0;
    repeat (16) begin tick(1); if (gate_h[0]) n++; end
    chk("pwm_high_count", n, 8);

    // First forward step with exact latency
    hall = 3'b011;
    tick(5); chk("step_lat5", gate_l, 3'b010);
    tick(1); chk("step_lat6", gate_l, 3'b000);
    tick(1); chk("step_lat7", gate_l, 3'b000);
    tick(1); chk("step_lat8", gate_l, 3'b100);
    for (int k = 0; k < 4; k++) begin
      tick(20);
      hall = fwd_codes[k];
      off = 0;
      repeat (40) begin tick(1); if (gate_l == 3'b000) off++; end
      chk("fwd_dead_cycles", off, DT);
      chk("fwd_low_pattern", gate_l, fwd_low[k]);
    end

    hall = 3'b001; dir = 1;
    tick(40); chk("rev_low", gate_l, 3'b001);
    bad = 0; n = 0;
    repeat (16) begin
      tick(1);
      if (gate_h != 3'b000 && gate_h != 3'b010) bad++;
      if (gate_h == 3'b010) n++;
    end
    chk("rev_high_phase", bad, 0);
    chk("rev_high_count", n, 8);
    dir = 0;
    tick(40); chk("fwd0_low", gate_l, 3'b010);

    hall = 3'b011; tick(1); hall = 3'b001;
    off = 0;
    repeat (20) begin tick(1); if (gate_l == 3'b000) off++; end
    chk("glitch_off", off, 0);
    chk("glitch_low", gate_l, 3'b010);

    en = 0;
    tick(1); chk("en_off_state", state, 2'b00); chk("en_off_gl1", gate_l, 3'b010);
    tick(1); chk("en_off_gates", {gate_h, gate_l}, 6'b0);
    en = 1; tick(40);

    fault_in = 1; tick(1); fault_in = 0;
    chk("fin_state", state, 2'b11); chk("fin_fault", fault, 1'b1);
    tick(1); chk("fin_gates", {gate_h, gate_l}, 6'b0);
    clr_fault = 1; fault_in = 1; tick(1);
    chk("clr_blocked", state, 2'b11);
    fault_in = 0; tick(1);
    chk("clr_ok", state, 2'b00);
    clr_fault = 0; tick(40);

    hall = 3'b111; tick(10);
    chk("hall111_state", state, 2'b11); chk("hall111_gates", {gate_h, gate_l}, 6'b0);
    hall = 3'b001; tick(10);
    duty = 4'd5;
    clr_fault = 1; tick(1); clr_fault = 0;
    chk("hall_clr", state, 2'b00);

    run_c = 0; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      if (state == 2'b10) run_c++;
      if (state == 2'b11) seen = 1;
    end
    chk("stall_fault_seen", seen, 1);
    chk("stall_run_cycles", run_c, SC);

    duty = 4'd0;
    clr_fault = 1; tick(1); clr_fault = 0;
    run_c = 0; seen = 0;
    repeat (300) begin
      tick(1);
      if (state == 2'b10) run_c++;
      if (state == 2'b11) seen = 1;
    end
    chk("duty0_no_fault", seen, 0);
    chk("duty0_running", run_c > 250, 1);

    rst_n = 0; tick(1);
    chk("midreset_state", state, 2'b00); chk("midreset_gates", {gate_h, gate_l}, 6'b0);
    rst_n = 1; duty = 4'd8;

    hidx = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 45) hidx = (hidx + 1) % 6;
        else if (r < 85) hidx = (hidx + 5) % 6;
        hall = (r < 93) ? seq[hidx] : 3'($urandom_range(0, 7));
      end
      if (en) en = ($urandom_range(0, 199) != 0);
      else    en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) dir = ~dir;
      if ($urandom_range(0, 39) == 0) duty = 4'($urandom_range(0, 15));
      fault_in  = ($urandom_range(0, 399) == 0);
      clr_fault = ($urandom_range(0, 29) == 0);
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
